// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S frame sequencer and its holding buffer.
package i2s_pkg;

   typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} ctrl_state_t;

   localparam int DEF_WIDTH = 16;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] left;
      logic [DEF_WIDTH-1:0] right;
   } sample_pair_t;

   function automatic int frame_len(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/i2s_hold_buf.sv
// One-entry valid/ready holding register; ready is simply "not full" so the
// producer never sees a combinational path from the consumer side.
module i2s_hold_buf
   import i2s_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          sclk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic          full,
   output logic [DW-1:0] data
);

   logic          full_reg;
   logic [DW-1:0] data_reg;
   logic          wr_fire;

   assign wr_fire = wr_valid && !full_reg;

   // rd_en is only raised while full, so it can never race a write.
   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         full_reg <= 1'b0;
         data_reg <= '0;
      end else begin
         if (wr_fire) begin
            data_reg <= wr_data;
            full_reg <= 1'b1;
         end else if (rd_en) begin
            full_reg <= 1'b0;
         end
      end
   end

   assign wr_ready = !full_reg;
   assign full     = full_reg;
   assign data     = data_reg;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S frame sequencer: bit counter, Philips word select, playback/capture handshakes.
// Define I2S_UNDERRUN_MUTE_EN to send silence instead of repeating samples on underrun.
module i2s_frame_ctrl
   import i2s_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int RX_CAP_CNT = 1,
   localparam int CNT_W      = $clog2(frame_len(WIDTH))
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr_status,
   output logic             ws_out,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             tx_load,
   output logic [WIDTH-1:0] tx_left,
   output logic [WIDTH-1:0] tx_right,
   input  logic [WIDTH-1:0] rx_left,
   input  logic [WIDTH-1:0] rx_right,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_left,
   input  logic [WIDTH-1:0] src_right,
   output logic             snk_valid,
   input  logic             snk_ready,
   output logic [WIDTH-1:0] snk_left,
   output logic [WIDTH-1:0] snk_right,
   output logic             underrun,
   output logic             overrun,
   output logic             running
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(frame_len(WIDTH) - 1);
   localparam logic [CNT_W-1:0] CAP  = CNT_W'(RX_CAP_CNT);

   ctrl_state_t        state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               ws_reg, ws_next;
   logic               load_reg, load_next;
   logic [WIDTH-1:0]   tx_left_reg, tx_right_reg;
   logic [WIDTH-1:0]   snk_left_reg, snk_right_reg;
   logic               snk_valid_reg;
   logic               underrun_reg, overrun_reg;
   logic               cnt_en, cap_en, load_en;
   logic               underrun_set, overrun_set;
   logic               hold_full;
   logic [2*WIDTH-1:0] hold_data;

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (en) state_next = SYNC;
         SYNC:    if (cnt_reg == LAST) state_next = en ? RUN : IDLE;
         RUN:     if (!en) state_next = DRAIN;
         DRAIN:   if (en) state_next = RUN;
                  else if (cnt_reg == LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Load is decided from the upcoming state so DRAIN suppresses it and a re-enable does not.
   always_comb begin
      running = (state_reg == RUN);
      cnt_en  = (state_reg != IDLE);
      cap_en  = ((state_reg == RUN) || (state_reg == DRAIN)) && (cnt_reg == CAP);
      load_en = (state_next == SYNC) || (state_next == RUN);
   end

   assign cnt_next     = cnt_en ? ((cnt_reg == LAST) ? '0 : cnt_reg + 1'b1) : '0;
   assign ws_next      = (cnt_next >= CNT_W'(WIDTH - 1)) && (cnt_next <= CNT_W'(2*WIDTH - 2));
   assign load_next    = load_en && (cnt_next == LAST);
   assign underrun_set = load_next && !hold_full;
   assign overrun_set  = cap_en && snk_valid_reg && !snk_ready;

   i2s_hold_buf #(.DW(2*WIDTH)) u_hold (
      .sclk     (sclk),
      .rst      (rst),
      .wr_valid (src_valid),
      .wr_ready (src_ready),
      .wr_data  ({src_left, src_right}),
      .rd_en    (load_next && hold_full),
      .full     (hold_full),
      .data     (hold_data)
   );

   always_ff @(posedge sclk or negedge rst) begin
      if (!rst) begin
         cnt_reg       <= '0;
         ws_reg        <= 1'b0;
         load_reg      <= 1'b0;
         tx_left_reg   <= '0;
         tx_right_reg  <= '0;
         snk_left_reg  <= '0;
         snk_right_reg <= '0;
         snk_valid_reg <= 1'b0;
         underrun_reg  <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         ws_reg   <= ws_next;
         load_reg <= load_next;
         if (load_next) begin
            if (hold_full) begin
               {tx_left_reg, tx_right_reg} <= hold_data;
            end
`ifdef I2S_UNDERRUN_MUTE_EN
            else begin
               tx_left_reg  <= '0;
               tx_right_reg <= '0;
            end
`endif
         end
         // A capture always wins over a same-cycle sink acceptance.
         if (cap_en) begin
            snk_left_reg  <= rx_left;
            snk_right_reg <= rx_right;
            snk_valid_reg <= 1'b1;
         end else if (snk_valid_reg && snk_ready) begin
            snk_valid_reg <= 1'b0;
         end
         underrun_reg <= underrun_set || (underrun_reg && !clr_status);
         overrun_reg  <= overrun_set  || (overrun_reg  && !clr_status);
      end
   end

   assign bit_cnt   = cnt_reg;
   assign ws_out    = ws_reg;
   assign tx_load   = load_reg;
   assign tx_left   = tx_left_reg;
   assign tx_right  = tx_right_reg;
   assign snk_valid = snk_valid_reg;
   assign snk_left  = snk_left_reg;
   assign snk_right = snk_right_reg;
   assign underrun  = underrun_reg;
   assign overrun   = overrun_reg;

endmodule

// File: doc/i2s_frame_ctrl.md
Name: i2s_frame_ctrl

Overview:
- Frame sequencer for the I2S audio path. Owns the bit counter and word-select timing and tells the I2S transmitter when to load new samples and when receiver words are complete.
- Decouples both directions from the DSP/LFO datapath with valid/ready handshakes: a one-entry playback buffer on the source side and a one-entry capture register on the sink side.

Parameters:
- WIDTH, 16, bits per channel word; frame length is 2*WIDTH sclk cycles.
- RX_CAP_CNT, 1, bit_cnt value at which completed receiver words are sampled; range 0..2*WIDTH-1.

Ports:
- sclk  in  1  bit clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request, level-sensitive.
- clr_status  in  1  synchronous clear of the sticky flags.
- ws_out  out  1  word select to the transmitter and external codec; 0 = left, 1 = right.
- bit_cnt  out  $clog2(2*WIDTH)  position in the frame.
- tx_load  out  1  one-cycle pulse; transmitter latches tx_left/tx_right.
- tx_left, tx_right  out  WIDTH  samples presented to the transmitter.
- rx_left, rx_right  in  WIDTH  parallel words from the receiver.
- src_valid  in  1  source handshake (DSP to playback).
- src_ready  out  1  source handshake.
- src_left, src_right  in  WIDTH  playback sample pair.
- snk_valid  out  1  sink handshake (capture to DSP).
- snk_ready  in  1  sink handshake.
- snk_left, snk_right  out  WIDTH  captured sample pair.
- underrun, overrun  out  1  sticky error flags.
- running  out  1  high in RUN state.

Behaviour:
- Reset values: state IDLE; bit_cnt 0; ws_out 0; tx_load 0; tx_left/tx_right 0; snk_* 0; src_ready 1; hold buffer empty; flags 0; running 0.
- Counter: bit_cnt increments every cycle outside IDLE and wraps 2*WIDTH-1 -> 0. It is held at 0 in IDLE.
- Word select (Philips timing): ws_out is a register updated from the next bit_cnt value.
  - ws_out = 1 for bit_cnt in WIDTH-1..2*WIDTH-2.
  - ws_out = 0 otherwise.
  - This means ws_out changes one cycle before each MSB.
- Frame boundary: tx_load pulses for one cycle when bit_cnt == 2*WIDTH-1, in SYNC and RUN. tx_left/tx_right are updated on that same edge.
- Playback source:
  - One-entry hold register; src_ready = !hold_full (registered).
  - Handshake: src_valid && src_ready writes the hold register and sets hold_full.
  - At tx_load, if hold_full: tx_* <= hold and hold_full is cleared.
  - At tx_load, if hold empty: underrun <= 1 and tx_* follow the Optional Feature rule.
  - If the hold register is written in the same cycle as an empty tx_load, the write still lands in the hold register. There is no bypass, and underrun is still set.
- Capture sink:
  - At bit_cnt == RX_CAP_CNT in RUN: snk_* <= rx_*, snk_valid <= 1.
  - snk_valid && snk_ready clears snk_valid, except in a capture cycle, where valid stays 1 with the new data.
  - Capture while snk_valid == 1 and !snk_ready sets overrun; the data is overwritten.
- FSM:
  - IDLE -> SYNC when en = 1.
  - SYNC: runs one full frame with the counter and tx_load active but capture suppressed, because receiver data is stale. SYNC -> RUN at bit_cnt wrap.
  - RUN -> DRAIN when en = 0.
  - DRAIN completes the current frame, including capture if still ahead, then goes to IDLE at wrap. tx_load is suppressed in DRAIN.
  - If en re-asserts during DRAIN, the block returns to RUN with no gap.
- clr_status: clears underrun and overrun. Setting the flags has priority over the clear in the same cycle.
- Reset mid-frame: all state returns to reset values immediately. Hold buffer contents are discarded.

Optional Feature:
- Macro I2S_UNDERRUN_MUTE_EN.
- Defined: an underrun loads 0 into tx_left and tx_right.
- Undefined: an underrun repeats the previous tx_left/tx_right values.
- In both cases the underrun flag is set.

Decomposition:
- Package i2s_pkg holds:
  - typedef ctrl_state_t {IDLE, SYNC, RUN, DRAIN};
  - function frame_len(WIDTH);
  - typedef for the sample-pair struct {left, right}.
- One sub-module: i2s_hold_buf, the one-entry valid/ready holding register reused for the source side.

Test Plan (WIDTH=16):
- Reset then en = 1:
  - SYNC lasts 32 cycles, then running = 1.
  - ws_out = 1 exactly while bit_cnt is 15..30.
  - tx_load pulses every 32 cycles, at bit_cnt = 31.
- Source pushes L=0xDEAD R=0xBEEF before a boundary:
  - tx_left/tx_right = DEAD/BEEF after tx_load; src_ready returns 1.
  - Loopback of the I2S transmitter into the receiver shows snk_left/snk_right = DEAD/BEEF one frame later.
- No source data at a boundary:
  - underrun = 1.
  - tx_* = previous value, or 0x0000 with I2S_UNDERRUN_MUTE_EN.
  - clr_status clears the flag.
- Hold snk_ready = 0 across two captures:
  - overrun = 1; snk_* hold the second pair.
  - snk_ready = 1 during a capture cycle leaves snk_valid = 1 and overrun = 0.
- en = 0 at bit_cnt = 10:
  - The frame completes and no tx_load occurs.
  - Block reaches IDLE with bit_cnt = 0 and ws_out = 0.
  - Repeat with en re-asserted at bit_cnt = 20: block stays in RUN.
- rst asserted at bit_cnt = 20 with the hold buffer full: all outputs return to reset values asynchronously, and src_ready = 1.
